// File: rtl/sem_pkg.sv
// sem_pkg: shared command width, FSM state encoding and SEM opcode nibbles.
package sem_pkg;
  localparam int SEM_CMD_W = 44;
  localparam logic [3:0] OP_ERR_INJECT = 4'hE;
  localparam logic [3:0] OP_OBSERVE = 4'hA;
  localparam logic [3:0] OP_IDLE = 4'hB;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_GAP} sem_q_state_t;
endpackage

// File: rtl/sem_cmd_fifo.sv
// sem_cmd_fifo: synchronous DEPTH x SEM_CMD_W command FIFO; a push while full is taken only alongside a pop.
module sem_cmd_fifo
  import sem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [SEM_CMD_W-1:0]    data_i,
  output logic [SEM_CMD_W-1:0]    data_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    full_o,
  output logic                    empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [SEM_CMD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] level_q;
  logic wr_en, rd_en;
  assign full_o  = level_q == (AW+1)'(DEPTH);
  assign empty_o = level_q == '0;
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  assign data_o  = mem_q[rd_q];
  assign level_o = level_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_q + AW'(wr_en);
      rd_q    <= rd_q + AW'(rd_en);
      level_q <= level_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/sem_command_queue.sv
// sem_command_queue: buffers generator commands and issues them one at a time to the SEM IP,
// waiting for busy acknowledge/completion and enforcing an idle gap between commands.
module sem_command_queue
  import sem_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int GAP_CYCLES  = 16,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEM_CMD_W-1:0]    in_code,
  input  logic                    in_strobe,
  output logic                    in_busy,
  input  logic                    sem_ready,
  input  logic                    sem_busy,
  output logic [SEM_CMD_W-1:0]    sem_code,
  output logic                    sem_strobe,
  output logic [$clog2(DEPTH):0]  level,
  output logic [7:0]              drop_count,
  output logic                    timeout_err,
  input  logic                    err_clr
);
  sem_q_state_t state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [SEM_CMD_W-1:0] code_q, code_d, head;
  logic strobe_q, strobe_d, terr_q, terr_d, timeout, full, empty, pop, drop;
  logic [7:0] drop_q, drop_d;
  sem_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(in_strobe), .pop_i(pop), .data_i(in_code),
    .data_o(head), .level_o(level), .full_o(full), .empty_o(empty)
  );
  assign pop         = state_q == S_ISSUE;
  assign drop        = in_strobe && full && !pop;
  assign in_busy     = full;
  assign sem_code    = code_q;
  assign sem_strobe  = strobe_q;
  assign drop_count  = drop_q;
  assign timeout_err = terr_q;
  assign drop_d      = err_clr ? 8'd0 : (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  assign terr_d      = err_clr ? 1'b0 : terr_q | timeout;
  // Strobe and code are registered on the IDLE->ISSUE edge so they appear during ISSUE.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    strobe_d = 1'b0;
    code_d   = code_q;
    timeout  = 1'b0;
    case (state_q)
      S_IDLE: if (!empty && sem_ready && !sem_busy) begin
        state_d  = S_ISSUE;
        strobe_d = 1'b1;
        code_d   = head;
      end
      S_ISSUE: begin
        state_d = S_WAIT_ACK;
        timer_d = '0;
      end
      S_WAIT_ACK: if (sem_busy) state_d = S_WAIT_DONE;
        else if (timer_q == 16'(ACK_TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = S_GAP;
          timer_d = '0;
        end else timer_d = timer_q + 16'd1;
      S_WAIT_DONE: if (!sem_busy) begin
        state_d = S_GAP;
        timer_d = '0;
      end
      S_GAP: if (timer_q == 16'(GAP_CYCLES - 1)) state_d = S_IDLE;
        else timer_d = timer_q + 16'd1;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      code_q   <= '0;
      strobe_q <= 1'b0;
      drop_q   <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      code_q   <= code_d;
      strobe_q <= strobe_d;
      drop_q   <= drop_d;
      terr_q   <= terr_d;
    end
  end
endmodule

// File: tb/tb_sem_command_queue.sv
// tb_sem_command_queue: scoreboard bench; accepted codes are queued at push and matched at each strobe.
module tb_sem_command_queue;
  import sem_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, in_strobe = 1'b0, sem_ready = 1'b0, sem_busy = 1'b0, err_clr = 1'b0;
  logic [SEM_CMD_W-1:0] in_code = '0, sem_code;
  logic in_busy, sem_strobe, timeout_err;
  logic [2:0] level;
  logic [7:0] drop_count;
  int checks = 0, failures = 0, nstrobe = 0, n0;
  logic prev_strobe = 1'b0;
  logic [SEM_CMD_W-1:0] exp_q [$];
  always #5 clk = ~clk;
  sem_command_queue #(.DEPTH(4), .GAP_CYCLES(16), .ACK_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_strobe(in_strobe), .in_busy(in_busy),
    .sem_ready(sem_ready), .sem_busy(sem_busy), .sem_code(sem_code), .sem_strobe(sem_strobe),
    .level(level), .drop_count(drop_count), .timeout_err(timeout_err), .err_clr(err_clr)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) prev_strobe = 1'b0;
    else begin
      if (sem_strobe) begin
        nstrobe++;
        chk("strobe_width", 64'(prev_strobe), 64'(0));
        chk("strobe_has_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) chk("sem_code", 64'(sem_code), 64'(exp_q.pop_front()));
      end
      prev_strobe = sem_strobe;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [SEM_CMD_W-1:0] c, input bit acc);
    in_code = c;
    in_strobe = 1'b1;
    if (acc) exp_q.push_back(c);
    tick();
    in_strobe = 1'b0;
  endtask
  task automatic wait_strobe(input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      seen = sem_strobe;
    end
    chk("strobe_within_budget", 64'(seen), 64'(1));
  endtask
  task automatic ack_tail();
    sem_busy = 1'b1;
    tick();
    tick();
    sem_busy = 1'b0;
    repeat (16) tick();
  endtask
  task automatic finish_cmd();
    tick();
    ack_tail();
  endtask
  initial begin
    logic [SEM_CMD_W-1:0] c1;
    c1 = {OP_ERR_INJECT, 40'h0003FFFC05};
    repeat (3) tick();
    chk("rst_strobe", 64'(sem_strobe), 64'(0));
    chk("rst_code", 64'(sem_code), 64'(0));
    chk("rst_in_busy", 64'(in_busy), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_drop", 64'(drop_count), 64'(0));
    chk("rst_terr", 64'(timeout_err), 64'(0));
    rst_n = 1'b1;
    tick();
    sem_ready = 1'b1;
    push(c1, 1'b1);
    chk("t1_level", 64'(level), 64'(1));
    chk("t1_early_strobe", 64'(sem_strobe), 64'(0));
    tick();
    chk("t1_strobe", 64'(sem_strobe), 64'(1));
    chk("t1_code", 64'(sem_code), 64'(c1));
    tick();
    sem_busy = 1'b1;
    push({OP_OBSERVE, 40'h1}, 1'b1);
    repeat (4) tick();
    sem_busy = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      tick();
      chk("t1_gap_strobe", 64'(sem_strobe), 64'(i == 18));
    end
    finish_cmd();
    sem_ready = 1'b0;
    for (int k = 0; k < 6; k++) push({OP_IDLE, 40'(k + 16)}, k < 4);
    chk("t2_level", 64'(level), 64'(4));
    chk("t2_in_busy", 64'(in_busy), 64'(1));
    chk("t2_drop", 64'(drop_count), 64'(2));
    sem_ready = 1'b1;
    repeat (4) begin
      wait_strobe(3);
      finish_cmd();
    end
    chk("t2_drained", 64'(level), 64'(0));
    sem_ready = 1'b0;
    push({OP_OBSERVE, 40'h33}, 1'b1);
    n0 = nstrobe;
    repeat (100) tick();
    chk("t3_no_strobe", 64'(nstrobe), 64'(n0));
    chk("t3_level", 64'(level), 64'(1));
    sem_ready = 1'b1;
    tick();
    chk("t3_strobe", 64'(sem_strobe), 64'(1));
    finish_cmd();
    push({OP_ERR_INJECT, 40'hA}, 1'b1);
    push({OP_ERR_INJECT, 40'hB}, 1'b1);
    chk("t4_strobe", 64'(sem_strobe), 64'(1));
    for (int i = 1; i <= 82; i++) begin
      tick();
      if (i == 64 || i == 65) chk("t4_timeout_err", 64'(timeout_err), 64'(i == 65));
      if (i >= 81) chk("t4_next_strobe", 64'(sem_strobe), 64'(i == 82));
    end
    finish_cmd();
    chk("t4_sticky", 64'(timeout_err), 64'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_clr_terr", 64'(timeout_err), 64'(0));
    chk("t4_clr_drop", 64'(drop_count), 64'(0));
    sem_ready = 1'b0;
    for (int k = 0; k < 4; k++) push({OP_OBSERVE, 40'(k + 48)}, 1'b1);
    chk("t5_full", 64'(level), 64'(4));
    sem_ready = 1'b1;
    tick();
    chk("t5_strobe", 64'(sem_strobe), 64'(1));
    push({OP_OBSERVE, 40'h5E}, 1'b1);
    chk("t5_level", 64'(level), 64'(4));
    chk("t5_drop", 64'(drop_count), 64'(0));
    chk("t5_in_busy", 64'(in_busy), 64'(1));
    ack_tail();
    repeat (4) begin
      wait_strobe(3);
      finish_cmd();
    end
    chk("t5_drained", 64'(level), 64'(0));
    sem_ready = 1'b0;
    for (int k = 0; k < 6; k++) push({OP_IDLE, 40'(k + 96)}, k < 4);
    chk("t6_pre_drop", 64'(drop_count), 64'(2));
    sem_ready = 1'b1;
    wait_strobe(3);
    tick();
    sem_busy = 1'b1;
    tick();
    tick();
    chk("t6_pre_level", 64'(level), 64'(3));
    rst_n = 1'b0;
    #1;
    chk("t6_strobe", 64'(sem_strobe), 64'(0));
    chk("t6_code", 64'(sem_code), 64'(0));
    chk("t6_level", 64'(level), 64'(0));
    chk("t6_in_busy", 64'(in_busy), 64'(0));
    chk("t6_drop", 64'(drop_count), 64'(0));
    chk("t6_terr", 64'(timeout_err), 64'(0));
    exp_q.delete();
    sem_busy = 1'b0;
    tick();
    rst_n = 1'b1;
    n0 = nstrobe;
    repeat (30) tick();
    chk("t6_quiet", 64'(nstrobe), 64'(n0));
    push({OP_ERR_INJECT, 40'hF}, 1'b1);
    tick();
    chk("t6_new_strobe", 64'(sem_strobe), 64'(1));
    finish_cmd();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
